// File: rtl/pqr5_subsystem_pkg.sv
// ---------------------------------------------------------------------------
// pqr5_subsystem_pkg
// Shared types for the data-memory access path.
//   lsu_size_t   : load/store access size encoding (2'b11 is illegal)
//   dmac_state_t : response-channel state of dmem_access_ctrl
//   p1_ctl_t     : per-request control captured in the accept cycle
//   lane_mask()  : byte-lane enable pattern for a size/offset pair
// ---------------------------------------------------------------------------
package pqr5_subsystem_pkg;

  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    DMAC_IDLE,
    DMAC_LIVE,
    DMAC_HELD
  } dmac_state_t;

  localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'b11;

  // Everything the response side needs to know about the request in flight.
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
    logic       err;
  } p1_ctl_t;

  // Byte lanes touched by an access. Misaligned halves never reach the RAM
  // (they are flagged as errors), so the shifted-out bit is irrelevant.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    case (size)
      LSU_B:   lane_mask = 4'b0001 << offset;
      LSU_H:   lane_mask = 4'b0011 << offset;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rdata_align.sv
// ---------------------------------------------------------------------------
// dmem_rdata_align
// Combinational load formatter: brings the addressed byte/half down to bit 0
// and sign- or zero-extends it. Shared with the instruction fetch path.
//   rdata       in  32  raw RAM word
//   offset      in  2   byte offset within the word
//   size        in  2   lsu_size_t encoding
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  formatted result
// ---------------------------------------------------------------------------
module dmem_rdata_align
  import pqr5_subsystem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        ext_bit;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data    = shifted;
    ext_bit = 1'b0;
    case (size)
      LSU_B: begin
        ext_bit = ~is_unsigned & shifted[7];
        data    = {{24{ext_bit}}, shifted[7:0]};
      end
      LSU_H: begin
        ext_bit = ~is_unsigned & shifted[15];
        data    = {{16{ext_bit}}, shifted[15:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Sole master of the 4-bank byte-enabled data RAM. Turns byte-addressed
// load/store requests into bank enables, word address and lane-replicated
// write data in the accept cycle, and returns formatted load data or a store
// ack one cycle later over a valid/ready channel with a one-entry hold
// register for backpressure.
//   clk, aresetn                 clock, asynchronous active-low reset
//   i_req_* / o_req_ready        request channel (valid/ready)
//   o_rsp_* / i_rsp_ready        response channel (valid/ready)
//   o_mem_en/wen/addr/wdata      RAM drive, combinational in the accept cycle
//   i_mem_rdata                  RAM read data, one cycle after the access
// ---------------------------------------------------------------------------
module dmem_access_ctrl
  import pqr5_subsystem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [TAG_W-1:0]  i_req_tag,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic              o_rsp_err,
  output logic [TAG_W-1:0]  o_rsp_tag,
  output logic [3:0]        o_mem_en,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  dmac_state_t      state_reg;
  p1_ctl_t          p1_ctl_reg;
  logic [TAG_W-1:0] p1_tag_reg;
  logic [31:0]      hold_data_reg;
  logic             hold_err_reg;
  logic [TAG_W-1:0] hold_tag_reg;

  logic        accept;
  logic        req_err;
  logic [31:0] fmt_data;
  logic [31:0] live_data;

  // A pending response only blocks new requests while it is being stalled.
  assign o_req_ready = (state_reg == DMAC_IDLE) || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    req_err = 1'b0;
    if (i_req_size == LSU_SIZE_ILLEGAL)                 req_err = 1'b1;
    if ((i_req_size == LSU_H) && i_req_addr[0])         req_err = 1'b1;
    if ((i_req_size == LSU_W) && (i_req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if ((i_req_addr >> (ADDR_W + 2)) != 32'd0)          req_err = 1'b1;
  end

  // RAM drive. Enables are additionally held off while in reset so no access
  // can slip through even if upstream misbehaves.
  assign o_mem_addr = i_req_addr[ADDR_W+1:2];
  assign o_mem_wen  = i_req_wr;
  assign o_mem_en   = (accept && !req_err && aresetn)
                      ? lane_mask(i_req_size, i_req_addr[1:0]) : 4'b0000;

  // Right-aligned store data is replicated across lanes so whichever bank the
  // enable selects sees the right byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wlane
      assign o_mem_wdata[8*gi +: 8] =
        (i_req_size == LSU_B) ? i_req_wdata[7:0] :
        (i_req_size == LSU_H) ? i_req_wdata[8*(gi%2) +: 8] :
                                i_req_wdata[8*gi +: 8];
    end
  endgenerate

  dmem_rdata_align u_align (
    .rdata       (i_mem_rdata),
    .offset      (p1_ctl_reg.offset),
    .size        (p1_ctl_reg.size),
    .is_unsigned (p1_ctl_reg.is_unsigned),
    .data        (fmt_data)
  );

  // Stores and faulted requests answer with zero data.
  assign live_data = (p1_ctl_reg.wr || p1_ctl_reg.err) ? 32'd0 : fmt_data;

  assign o_rsp_valid = (state_reg != DMAC_IDLE);

  always_comb begin
    o_rsp_data = 32'd0;
    o_rsp_err  = 1'b0;
    o_rsp_tag  = '0;
    case (state_reg)
      DMAC_LIVE: begin
        o_rsp_data = live_data;
        o_rsp_err  = p1_ctl_reg.err;
        o_rsp_tag  = p1_tag_reg;
      end
      DMAC_HELD: begin
        o_rsp_data = hold_data_reg;
        o_rsp_err  = hold_err_reg;
        o_rsp_tag  = hold_tag_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= DMAC_IDLE;
      p1_ctl_reg    <= '0;
      p1_tag_reg    <= '0;
      hold_data_reg <= 32'd0;
      hold_err_reg  <= 1'b0;
      hold_tag_reg  <= '0;
    end else begin
      if (accept) begin
        p1_ctl_reg.wr          <= i_req_wr;
        p1_ctl_reg.size        <= i_req_size;
        p1_ctl_reg.is_unsigned <= i_req_unsigned;
        p1_ctl_reg.offset      <= i_req_addr[1:0];
        p1_ctl_reg.err         <= req_err;
        p1_tag_reg             <= i_req_tag;
      end
      case (state_reg)
        DMAC_IDLE: begin
          if (accept) state_reg <= DMAC_LIVE;
        end
        DMAC_LIVE: begin
          if (i_rsp_ready) begin
            state_reg <= accept ? DMAC_LIVE : DMAC_IDLE;
          end else begin
            // RAM read data is only guaranteed for this one cycle; freeze it.
            hold_data_reg <= live_data;
            hold_err_reg  <= p1_ctl_reg.err;
            hold_tag_reg  <= p1_tag_reg;
            state_reg     <= DMAC_HELD;
          end
        end
        DMAC_HELD: begin
          if (i_rsp_ready) state_reg <= accept ? DMAC_LIVE : DMAC_IDLE;
        end
        default: state_reg <= DMAC_IDLE;
      endcase
    end
  end

endmodule
